// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: monitors a free-running modulo counter.
// Checks +1 advance with CNT_MAX->0 wrap, tracks lock, counts wraps and errors.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         1 = sample and check cnt_in this cycle
//   cnt_in     counter value under test
//   clr        synchronous clear of statistics and first-error capture
//   locked     sequence locked
//   err_pulse  one-cycle pulse per detected error
//   err_sticky set on first error, held until clr/rst
//   err_cnt    saturating error count
//   wrap_cnt   saturating count of CNT_MAX->0 transitions seen while locked
//   exp_val    expected value at the first error
//   bad_val    received value at the first error
//
// Optional feature macro: CNT_CHK_HOLD_EN
//   When defined, a repeated sample while locked is a tolerated stall of up
//   to HOLD_MAX consecutive repeats; the next repeat is an error.

module cnt_seq_checker #(
    parameter int CNT_W    = 8,
    parameter int CNT_MAX  = 255,
    parameter int LOCK_N   = 4,
    parameter int ERR_W    = 16,
    parameter int WRAP_W   = 16,
    parameter int HOLD_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0]  exp_val,
    output logic [CNT_W-1:0]  bad_val
);

    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W:0]   MAX_WV = (CNT_W+1)'(CNT_MAX);
    localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] prev;
    logic             prev_valid;
    logic [3:0]       good;

    logic [CNT_W-1:0] exp;
    logic             oor;
    logic             match;
    logic             err_ev;
    logic             wrap_ev;

`ifdef CNT_CHK_HOLD_EN
    localparam int HW = $clog2(HOLD_MAX + 2);
    localparam logic [HW-1:0] HOLD_V = HW'(HOLD_MAX);

    logic [HW-1:0] hold_run;
    logic          rpt;
    logic          hold_ok;
`else
    // HOLD_MAX only matters when the hold feature is built in.
    logic unused_hold;
    assign unused_hold = ^{1'b0, 32'(HOLD_MAX)};
`endif

    // Next expected value, wrapping at the terminal count. The range
    // check is done one bit wider so it never folds to a constant.
    always_comb begin
        exp   = (prev == MAX_V) ? '0 : prev + CNT_W'(1);
        oor   = {1'b0, cnt_in} > MAX_WV;
        match = prev_valid && (cnt_in == exp);
    end

`ifdef CNT_CHK_HOLD_EN
    always_comb begin
        rpt     = prev_valid && (cnt_in == prev);
        hold_ok = rpt && (hold_run < HOLD_V);
    end
`endif

    // Error and wrap events for this cycle, consumed by the statistics.
    always_comb begin
        err_ev  = 1'b0;
        wrap_ev = 1'b0;
        if (en) begin
            unique case (state)
                ACQ: begin
                    err_ev = oor;
                end
                LOCK: begin
`ifdef CNT_CHK_HOLD_EN
                    err_ev = oor || (!match && !hold_ok);
`else
                    err_ev = oor || !match;
`endif
                    wrap_ev = !oor && match && (prev == MAX_V);
                end
                default: begin
                    err_ev  = 1'b0;
                    wrap_ev = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= '0;
            prev_valid <= 1'b0;
            good       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            exp_val    <= '0;
            bad_val    <= '0;
`ifdef CNT_CHK_HOLD_EN
            hold_run   <= '0;
`endif
        end else begin
            err_pulse <= err_ev;

            // Sequence state machine
            if (!en) begin
                state      <= IDLE;
                locked     <= 1'b0;
                prev_valid <= 1'b0;
                good       <= '0;
`ifdef CNT_CHK_HOLD_EN
                hold_run   <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        // Out-of-range samples never seed the sequence.
                        if (!oor) begin
                            prev       <= cnt_in;
                            prev_valid <= 1'b1;
                            good       <= '0;
                            state      <= ACQ;
                        end
                    end
                    ACQ: begin
                        if (oor) begin
                            prev_valid <= 1'b0;
                            locked     <= 1'b0;
                            good       <= '0;
                            state      <= IDLE;
                        end else if (match) begin
                            prev <= cnt_in;
                            good <= good + 4'd1;
                            if (good + 4'd1 == LOCK_V) begin
                                state  <= LOCK;
                                locked <= 1'b1;
`ifdef CNT_CHK_HOLD_EN
                                hold_run <= '0;
`endif
                            end
`ifdef CNT_CHK_HOLD_EN
                        end else if (rpt) begin
                            // Stalled counter: no progress, no penalty.
                            good <= good;
`endif
                        end else begin
                            prev <= cnt_in;
                            good <= '0;
                        end
                    end
                    LOCK: begin
                        if (oor) begin
                            prev_valid <= 1'b0;
                            locked     <= 1'b0;
                            good       <= '0;
                            state      <= IDLE;
`ifdef CNT_CHK_HOLD_EN
                            hold_run   <= '0;
`endif
                        end else if (match) begin
                            prev <= cnt_in;
`ifdef CNT_CHK_HOLD_EN
                            hold_run <= '0;
                        end else if (hold_ok) begin
                            hold_run <= hold_run + HW'(1);
`endif
                        end else begin
                            prev   <= cnt_in;
                            good   <= '0;
                            locked <= 1'b0;
                            state  <= ACQ;
`ifdef CNT_CHK_HOLD_EN
                            hold_run <= '0;
`endif
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        locked     <= 1'b0;
                        prev_valid <= 1'b0;
                        good       <= '0;
                    end
                endcase
            end

            // Statistics and first-error capture; clr wins over events.
            if (clr) begin
                err_cnt    <= '0;
                wrap_cnt   <= '0;
                err_sticky <= 1'b0;
                exp_val    <= '0;
                bad_val    <= '0;
            end else begin
                if (err_ev) begin
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                    if (!err_sticky) begin
                        exp_val    <= exp;
                        bad_val    <= cnt_in;
                        err_sticky <= 1'b1;
                    end
                end
                if (wrap_ev && (wrap_cnt != '1)) begin
                    wrap_cnt <= wrap_cnt + WRAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb_cnt_seq_checker: directed-vector bench for cnt_seq_checker.
// Instance a uses CNT_MAX=255, instance b uses CNT_MAX=9.

module tb_cnt_seq_checker;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        en_a, en_b;
    logic        clr_a, clr_b;
    logic [7:0]  cnt_a, cnt_b;

    logic        locked_a, pulse_a, sticky_a;
    logic [15:0] errc_a, wrapc_a;
    logic [7:0]  expv_a, badv_a;

    logic        locked_b, pulse_b, sticky_b;
    logic [15:0] errc_b, wrapc_b;
    logic [7:0]  expv_b, badv_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cnt_seq_checker #(
        .CNT_W(8), .CNT_MAX(255), .LOCK_N(4),
        .ERR_W(16), .WRAP_W(16), .HOLD_MAX(3)
    ) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .cnt_in(cnt_a), .clr(clr_a),
        .locked(locked_a), .err_pulse(pulse_a), .err_sticky(sticky_a),
        .err_cnt(errc_a), .wrap_cnt(wrapc_a),
        .exp_val(expv_a), .bad_val(badv_a)
    );

    cnt_seq_checker #(
        .CNT_W(8), .CNT_MAX(9), .LOCK_N(4),
        .ERR_W(16), .WRAP_W(16), .HOLD_MAX(3)
    ) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .cnt_in(cnt_b), .clr(clr_b),
        .locked(locked_b), .err_pulse(pulse_b), .err_sticky(sticky_b),
        .err_cnt(errc_b), .wrap_cnt(wrapc_b),
        .exp_val(expv_b), .bad_val(badv_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic step_a(input logic e, input logic [7:0] v,
                          input logic c);
        en_a = e; cnt_a = v; clr_a = c;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic e, input logic [7:0] v);
        en_b = e; cnt_b = v;
        @(posedge clk); #1;
    endtask

    logic seen;

    initial begin
        rst_a = 1; rst_b = 1;
        en_a = 0; en_b = 0; clr_a = 0; clr_b = 0;
        cnt_a = 0; cnt_b = 0;
        step_a(1, 8'd77, 1);
        step_a(1, 8'd78, 0);
        check("rst_locked", locked_a, 0);
        check("rst_pulse", pulse_a, 0);
        check("rst_sticky", sticky_a, 0);
        check("rst_errc", errc_a, 0);
        check("rst_wrapc", wrapc_a, 0);
        check("rst_exp_bad", {expv_a, badv_a}, 0);
        rst_a = 0; rst_b = 0;

        // Acquire: 0..4 locks after sample 4
        for (int i = 0; i <= 3; i++) step_a(1, 8'(i), 0);
        check("acq_not_yet", locked_a, 0);
        step_a(1, 8'd4, 0);
        check("acq_locked", locked_a, 1);
        step_a(1, 8'd5, 0);
        check("acq_errc", errc_a, 0);
        check("acq_sticky", sticky_a, 0);

        // Three full laps through 255->0
        seen = 0;
        for (int i = 6; i <= 768; i++) begin
            step_a(1, 8'(i % 256), 0);
            seen |= pulse_a;
        end
        check("wrap_cnt3", wrapc_a, 3);
        check("wrap_no_pulse", seen, 0);

        // Error 11 -> 20
        for (int i = 1; i <= 11; i++) step_a(1, 8'(i), 0);
        step_a(1, 8'd20, 0);
        check("e1_pulse", pulse_a, 1);
        check("e1_errc", errc_a, 1);
        check("e1_sticky", sticky_a, 1);
        check("e1_exp", expv_a, 12);
        check("e1_bad", badv_a, 20);
        check("e1_unlock", locked_a, 0);
        step_a(1, 8'd21, 0);
        check("e1_pulse_off", pulse_a, 0);
        step_a(1, 8'd22, 0);
        step_a(1, 8'd23, 0);
        check("relock_not_yet", locked_a, 0);
        step_a(1, 8'd24, 0);
        check("relock", locked_a, 1);

        // Second error while sticky: capture frozen
        for (int i = 25; i <= 30; i++) step_a(1, 8'(i), 0);
        step_a(1, 8'd40, 0);
        check("e2_pulse", pulse_a, 1);
        check("e2_errc", errc_a, 2);
        check("e2_exp_frozen", expv_a, 12);
        check("e2_bad_frozen", badv_a, 20);
        for (int i = 41; i <= 44; i++) step_a(1, 8'(i), 0);
        check("e2_relock", locked_a, 1);

        // Third error coincident with clr
        step_a(1, 8'd50, 1);
        check("clr_pulse", pulse_a, 1);
        check("clr_errc", errc_a, 0);
        check("clr_sticky", sticky_a, 0);
        check("clr_wrapc", wrapc_a, 0);
        check("clr_exp_bad", {expv_a, badv_a}, 0);
        check("clr_unlock", locked_a, 0);
        step_a(1, 8'd51, 0);
        check("clr_pulse_off", pulse_a, 0);

        // CNT_MAX = 9 instance
        for (int i = 0; i <= 4; i++) step_b(1, 8'(i));
        check("b_locked", locked_b, 1);
        for (int i = 5; i <= 9; i++) step_b(1, 8'(i));
        step_b(1, 8'd0);
        check("b_wrap1", wrapc_b, 1);
        step_b(1, 8'd12);
        check("b_oor_pulse", pulse_b, 1);
        check("b_oor_unlock", locked_b, 0);
        check("b_oor_errc", errc_b, 1);
        check("b_oor_exp", expv_b, 1);
        check("b_oor_bad", badv_b, 12);
        step_b(1, 8'd15);
        check("b_idle_oor_ign", pulse_b, 0);
        check("b_idle_oor_errc", errc_b, 1);
        step_b(0, 8'd7);
        check("b_en0_pulse", pulse_b, 0);
        check("b_en0_errc_held", errc_b, 1);
        check("b_en0_wrap_held", wrapc_b, 1);
        step_b(1, 8'd5);
        check("b_restart_pulse", pulse_b, 0);
        for (int i = 6; i <= 8; i++) step_b(1, 8'(i));
        check("b_relock_not_yet", locked_b, 0);
        step_b(1, 8'd9);
        check("b_relock", locked_b, 1);
        step_b(1, 8'd0);
        check("b_wrap2", wrapc_b, 2);
        check("b_errc_final", errc_b, 1);

        // Repeated samples while locked
        rst_a = 1;
        step_a(0, 8'd0, 0);
        rst_a = 0;
        for (int i = 3; i <= 7; i++) step_a(1, 8'(i), 0);
        check("h_locked", locked_a, 1);
`ifdef CNT_CHK_HOLD_EN
        for (int i = 0; i < 3; i++) step_a(1, 8'd7, 0);
        check("h_hold3_errc", errc_a, 0);
        check("h_hold3_lock", locked_a, 1);
        step_a(1, 8'd8, 0);
        check("h_adv_errc", errc_a, 0);
        check("h_adv_lock", locked_a, 1);
        step_a(1, 8'd9, 0);
        for (int i = 0; i < 3; i++) step_a(1, 8'd9, 0);
        check("h_r3_errc", errc_a, 0);
        step_a(1, 8'd9, 0);
        check("h_r4_pulse", pulse_a, 1);
        check("h_r4_errc", errc_a, 1);
        check("h_r4_unlock", locked_a, 0);
        step_a(1, 8'd9, 0);
        check("h_r5_pulse", pulse_a, 0);
        check("h_r5_errc", errc_a, 1);
`else
        step_a(1, 8'd7, 0);
        check("r_pulse", pulse_a, 1);
        check("r_errc", errc_a, 1);
        check("r_exp", expv_a, 8);
        check("r_bad", badv_a, 7);
        check("r_unlock", locked_a, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnt_seq_checker.md
Name: cnt_seq_checker

Overview:
Downstream consumer of the free-running modulo counter.
- Samples the counter value every enabled cycle and checks that it advances by exactly +1, wrapping from CNT_MAX to 0.
- Reports lock status, counts wraps and sequence errors, and captures the first error.
- Used as the on-chip/bench monitor attached directly to the counter output.

Parameters:
CNT_W, 8, width of the monitored counter value
CNT_MAX, 255, terminal count; the value after CNT_MAX is 0
LOCK_N, 4, consecutive correct transitions required to declare lock (range 1..15)
ERR_W, 16, width of the error counter (saturating)
WRAP_W, 16, width of the wrap counter (saturating)
HOLD_MAX, 3, max consecutive repeated samples tolerated (CNT_CHK_HOLD_EN only)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous reset, active-high
en  input  1  1 = sample and check cnt_in this cycle; 0 = checking disabled
cnt_in  input  CNT_W  counter value under test
clr  input  1  synchronous clear of statistics and capture registers
locked  output  1  sequence locked
err_pulse  output  1  one-cycle pulse per detected error
err_sticky  output  1  set on first error, held until clr or rst
err_cnt  output  ERR_W  saturating error count
wrap_cnt  output  WRAP_W  saturating count of CNT_MAX->0 transitions seen while locked
exp_val  output  CNT_W  expected value at the first error
bad_val  output  CNT_W  received value at the first error

Behaviour:
- Reset: synchronous, active-high. Reset values:
  - all outputs 0
  - state IDLE
  - prev_valid 0, good counter 0
  - rst has priority over every other input.
- Output timing: all outputs are registered. A sample presented at edge N is reflected in the outputs after edge N, i.e. latency 1.
- exp = (prev == CNT_MAX) ? 0 : prev+1, computed at CNT_W bits. Any cnt_in > CNT_MAX is out-of-range.
- IDLE:
  - en=1 with an in-range sample: prev<=cnt_in, prev_valid<=1, good<=0, go to ACQ.
  - An out-of-range sample in IDLE is ignored.
- ACQ:
  - cnt_in==exp: prev<=cnt_in, good++. When good reaches LOCK_N, go to LOCK and set locked=1.
  - In-range mismatch: prev<=cnt_in, good<=0, stay in ACQ. No error is reported during acquisition.
- LOCK:
  - cnt_in==exp: prev<=cnt_in. If the transition is CNT_MAX->0, wrap_cnt++ (saturating).
  - Mismatch: error. err_pulse=1 for one cycle, err_cnt++ (saturating at all-ones).
    - If err_sticky was 0: exp_val<=exp and bad_val<=cnt_in, then err_sticky<=1.
    - prev<=cnt_in, good<=0, locked<=0, go to ACQ.
- Out-of-range sample in ACQ or LOCK:
  - Raises an error as above; exp_val is captured as exp.
  - prev_valid<=0, locked<=0, go to IDLE. The next in-range sample reloads prev.
- en=0: no comparison. Next state is IDLE, locked<=0, prev_valid<=0. Statistics and capture registers are held.
- clr=1:
  - err_cnt, wrap_cnt, err_sticky, exp_val and bad_val go to 0 next cycle.
  - The state machine is unaffected.
  - An error or wrap in the same cycle as clr is discarded from the statistics (clr wins). err_pulse still fires and state still transitions.
- First-error capture is frozen after the first error until clr.
- Saturation: err_cnt and wrap_cnt stop at 2^W-1 and never wrap.

Optional Feature:
CNT_CHK_HOLD_EN
- Defined: in LOCK, cnt_in==prev is a valid hold (counter stalled by its enable). It is neither an error nor a wrap.
  - The hold-run counter increments on each repeat and resets on any advance.
  - The (HOLD_MAX+1)th consecutive repeat is an error, handled as a LOCK mismatch.
  - In ACQ, a repeat leaves good unchanged.
- Not defined: a repeated value is an ordinary mismatch. HOLD_MAX is unused and no hold-run counter is synthesised.

Test Plan:
- rst, en=1, CNT_MAX=255, feed 0,1,2,3,4,5 -> locked=1 the cycle after sample 4; err_cnt=0, err_sticky=0.
- Locked, run 3 full cycles through 255->0 -> wrap_cnt=3, err_pulse never asserted.
- Locked, feed 10,11,20,21,22,23,24 -> err_pulse one cycle after 20, err_cnt=1, err_sticky=1, exp_val=12, bad_val=20, locked=0; relocks after 24.
- Second error 30->40 while sticky -> err_cnt=2, exp_val/bad_val stay 12/20. Then clr=1 coincident with a third error -> err_cnt=0, err_sticky=0, err_pulse=1.
- CNT_MAX=9, locked, feed 9,0 -> wrap_cnt+1. Feed 12 -> error, locked=0, state IDLE. en=0 then en=1 with value 5 -> no error, relock after 4 correct steps.
- With CNT_CHK_HOLD_EN, HOLD_MAX=3: locked, feed 7,7,7,7 -> no error, feed 8 -> ok. Feed 9 then five 9s -> error on the 4th repeat (5th sample). Without the macro: 7,7 -> error on the 2nd 7.
